// File: rtl/id_pkg.sv
// Shared decode constants, immediate formats and helpers for the
// registered RV32I decode stage (id_stage_fwd) and its forwarding resolver.
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_SPC = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_MEM = 2'b11;

    localparam logic [5:0] SEL_LUI   = {1'b0, CLS_SPC, 3'b000};
    localparam logic [5:0] SEL_AUIPC = {1'b0, CLS_SPC, 3'b001};
    localparam logic [5:0] SEL_JAL   = {1'b0, CLS_SPC, 3'b010};
    localparam logic [5:0] SEL_JALR  = {1'b0, CLS_SPC, 3'b011};
    localparam logic [5:0] SEL_SB    = {1'b0, CLS_MEM, 3'b000};
    localparam logic [5:0] SEL_SH    = {1'b0, CLS_MEM, 3'b001};
    localparam logic [5:0] SEL_SW    = {1'b0, CLS_MEM, 3'b010};

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

    typedef struct packed {
        logic       re1;
        logic       re2;
        logic       wreg;
        logic       illegal;
        logic [5:0] alusel;
        imm_fmt_e   fmt;
    } dec_t;

    // 32-bit sign-extended immediate for the given format.
    function automatic logic [31:0] imm_gen(
        input logic [31:0] i,
        input imm_fmt_e    fmt
    );
        logic [31:0] r;
        r = '0;
        unique case (fmt)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7],
                          i[30:25], i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12],
                          i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fwd_resolve.sv
// Resolves one source operand over NUM_FWD prioritised forwarding slots.
// Ports: en/addr select the source; rf_data is the regfile value;
// fwd_* are the slot buses (slot 0 youngest); data/hazard are results.
module fwd_resolve #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic                    en,
    input  logic [4:0]              addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [5*NUM_FWD-1:0]    fwd_wd,
    input  logic [NUM_FWD-1:0]      fwd_pend,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic [XLEN-1:0]         data,
    output logic                    hazard
);

    logic hit;

    always_comb begin
        data   = rf_data;
        hazard = 1'b0;
        hit    = 1'b0;
        // First matching slot wins; older slots are shadowed by it,
        // even when the younger one is still pending.
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit && fwd_we[i] && fwd_wd[5*i +: 5] == addr) begin
                hit    = 1'b1;
                data   = fwd_data[XLEN*i +: XLEN];
                hazard = fwd_pend[i];
            end
        end
        if (!en || addr == 5'd0) begin
            data   = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_fwd.sv
// Registered RV32I decode stage with forwarding, load-use stall and
// valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active-low), flush; if_* input side with
// id_ready; rf_* regfile read port; fwd_* forwarding slots; ex_* output
// register with ex_valid/ex_ready; stall_cnt saturating hazard counter.
module id_stage_fwd
    import id_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 3,
    parameter int ALUSEL_W    = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    if_valid,
    input  logic [XLEN-1:0]         if_pc,
    input  logic [31:0]             if_inst,
    output logic                    id_ready,
    output logic                    rf_re1,
    output logic                    rf_re2,
    output logic [4:0]              rf_addr1,
    output logic [4:0]              rf_addr2,
    input  logic [XLEN-1:0]         rf_data1,
    input  logic [XLEN-1:0]         rf_data2,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [5*NUM_FWD-1:0]    fwd_wd,
    input  logic [NUM_FWD-1:0]      fwd_pend,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic                    ex_valid,
    input  logic                    ex_ready,
    output logic [ALUSEL_W-1:0]     ex_alusel,
    output logic [XLEN-1:0]         ex_opr1,
    output logic [XLEN-1:0]         ex_opr2,
    output logic [XLEN-1:0]         ex_opr3,
    output logic [XLEN-1:0]         ex_opr4,
    output logic [4:0]              ex_wd,
    output logic                    ex_wreg,
    output logic                    ex_illegal,
    output logic [31:0]             ex_inst,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);

    state_e          state;
    dec_t            dec;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] res1;
    logic [XLEN-1:0] res2;
    logic [XLEN-1:0] opr1;
    logic [XLEN-1:0] opr2;
    logic            haz1;
    logic            haz2;
    logic            hazard;
    logic            accept;

    assign opc = if_inst[6:0];
    assign f3  = if_inst[14:12];
    assign rd  = if_inst[11:7];

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (opc == OPC_OPIMM): begin
                dec.re1    = 1'b1;
                dec.wreg   = 1'b1;
                dec.fmt    = IMM_I;
                // Only shift-immediates carry the arith/logic bit.
                dec.alusel = {if_inst[30] & (f3[1:0] == 2'b01),
                              CLS_ALU, f3};
            end
            (opc == OPC_OP): begin
                dec.re1    = 1'b1;
                dec.re2    = 1'b1;
                dec.wreg   = 1'b1;
                dec.alusel = {if_inst[30], CLS_ALU, f3};
            end
            (opc == OPC_LUI): begin
                dec.wreg   = 1'b1;
                dec.fmt    = IMM_U;
                dec.alusel = SEL_LUI;
            end
            (opc == OPC_AUIPC): begin
                dec.wreg   = 1'b1;
                dec.fmt    = IMM_U;
                dec.alusel = SEL_AUIPC;
            end
            (opc == OPC_JAL): begin
                dec.wreg   = 1'b1;
                dec.fmt    = IMM_J;
                dec.alusel = SEL_JAL;
            end
            (opc == OPC_JALR): begin
                dec.re1    = 1'b1;
                dec.wreg   = 1'b1;
                dec.fmt    = IMM_I;
                dec.alusel = SEL_JALR;
            end
            (opc == OPC_BRANCH): begin
                dec.re1    = 1'b1;
                dec.re2    = 1'b1;
                dec.fmt    = IMM_B;
                dec.alusel = {1'b0, CLS_BR, f3};
            end
            (opc == OPC_LOAD): begin
                dec.re1    = 1'b1;
                dec.wreg   = 1'b1;
                dec.fmt    = IMM_I;
                dec.alusel = {1'b0, CLS_MEM, f3};
            end
            (opc == OPC_STORE): begin
                dec.re1 = 1'b1;
                dec.re2 = 1'b1;
                dec.fmt = IMM_S;
                unique case (f3)
                    3'b000:  dec.alusel = SEL_SB;
                    3'b001:  dec.alusel = SEL_SH;
                    3'b010:  dec.alusel = SEL_SW;
                    default: begin
                        dec.alusel  = {1'b0, CLS_MEM, f3};
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (rd == 5'd0) begin
            dec.wreg = 1'b0;
        end
    end

    assign imm32 = imm_gen(if_inst, dec.fmt);
    assign imm   = XLEN'($signed(imm32));

    assign rf_re1   = dec.re1;
    assign rf_re2   = dec.re2;
    assign rf_addr1 = if_inst[19:15];
    assign rf_addr2 = if_inst[24:20];

    fwd_resolve #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_res1 (
        .en       (dec.re1),
        .addr     (rf_addr1),
        .rf_data  (rf_data1),
        .fwd_we   (fwd_we),
        .fwd_wd   (fwd_wd),
        .fwd_pend (fwd_pend),
        .fwd_data (fwd_data),
        .data     (res1),
        .hazard   (haz1)
    );

    fwd_resolve #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_res2 (
        .en       (dec.re2),
        .addr     (rf_addr2),
        .rf_data  (rf_data2),
        .fwd_we   (fwd_we),
        .fwd_wd   (fwd_wd),
        .fwd_pend (fwd_pend),
        .fwd_data (fwd_data),
        .data     (res2),
        .hazard   (haz2)
    );

    assign opr1   = dec.re1 ? res1 : imm;
    assign opr2   = dec.re2 ? res2 : imm;
    assign hazard = if_valid & (haz1 | haz2);

    assign id_ready = rst & ~flush & ~hazard
                    & (state == ST_EMPTY | ex_ready);
    assign accept   = if_valid & id_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_EMPTY;
            ex_valid   <= 1'b0;
            ex_alusel  <= '0;
            ex_opr1    <= '0;
            ex_opr2    <= '0;
            ex_opr3    <= '0;
            ex_opr4    <= '0;
            ex_wd      <= '0;
            ex_wreg    <= 1'b0;
            ex_illegal <= 1'b0;
            ex_inst    <= '0;
            stall_cnt  <= '0;
        end else begin
            if (if_valid && hazard && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
            if (flush) begin
                state    <= ST_EMPTY;
                ex_valid <= 1'b0;
            end else if (accept) begin
                state      <= ST_FULL;
                ex_valid   <= 1'b1;
                ex_alusel  <= ALUSEL_W'(dec.alusel);
                ex_opr1    <= opr1;
                ex_opr2    <= opr2;
                ex_opr3    <= imm;
                ex_opr4    <= if_pc;
                ex_wd      <= rd;
                ex_wreg    <= dec.wreg;
                ex_illegal <= dec.illegal;
                ex_inst    <= if_inst;
            end else if (state == ST_FULL && ex_ready) begin
                state    <= ST_EMPTY;
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: decode vector table plus hand-written
// forwarding, load-use, back-pressure and flush sequences.
module tb_id_stage_fwd;

    localparam int XLEN = 32;
    localparam int NF   = 3;
    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [31:0]       if_inst;
    logic              id_ready;
    logic              rf_re1, rf_re2;
    logic [4:0]        rf_addr1, rf_addr2;
    logic [XLEN-1:0]   rf_data1, rf_data2;
    logic [NF-1:0]     fwd_we;
    logic [5*NF-1:0]   fwd_wd;
    logic [NF-1:0]     fwd_pend;
    logic [XLEN*NF-1:0] fwd_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [5:0]        ex_alusel;
    logic [XLEN-1:0]   ex_opr1, ex_opr2, ex_opr3, ex_opr4;
    logic [4:0]        ex_wd;
    logic              ex_wreg;
    logic              ex_illegal;
    logic [31:0]       ex_inst;
    logic [15:0]       stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_stage_fwd dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .id_ready   (id_ready),
        .rf_re1     (rf_re1),
        .rf_re2     (rf_re2),
        .rf_addr1   (rf_addr1),
        .rf_addr2   (rf_addr2),
        .rf_data1   (rf_data1),
        .rf_data2   (rf_data2),
        .fwd_we     (fwd_we),
        .fwd_wd     (fwd_wd),
        .fwd_pend   (fwd_pend),
        .fwd_data   (fwd_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_alusel  (ex_alusel),
        .ex_opr1    (ex_opr1),
        .ex_opr2    (ex_opr2),
        .ex_opr3    (ex_opr3),
        .ex_opr4    (ex_opr4),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .ex_illegal (ex_illegal),
        .ex_inst    (ex_inst),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  sel;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [31:0] o3;
        logic [4:0]  wd;
        logic        wreg;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic we,
                            input logic [4:0] wd, input logic pend,
                            input logic [31:0] d);
        fwd_we[s]          = we;
        fwd_wd[5*s +: 5]   = wd;
        fwd_pend[s]        = pend;
        fwd_data[32*s +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h0050_0093, 6'h00, 32'h0, 32'd5, 32'd5,
                     5'd1, 1'b1, 1'b0};
        vecs[1]  = '{32'h0020_81B3, 6'h00, R1, R2, 32'h0,
                     5'd3, 1'b1, 1'b0};
        vecs[2]  = '{32'h4020_81B3, 6'h20, R1, R2, 32'h0,
                     5'd3, 1'b1, 1'b0};
        vecs[3]  = '{32'h4033_5293, 6'h25, R1, 32'h403, 32'h403,
                     5'd5, 1'b1, 1'b0};
        vecs[4]  = '{32'h1234_53B7, 6'h08, 32'h1234_5000,
                     32'h1234_5000, 32'h1234_5000, 5'd7, 1'b1, 1'b0};
        vecs[5]  = '{32'hFFFF_F417, 6'h09, 32'hFFFF_F000,
                     32'hFFFF_F000, 32'hFFFF_F000, 5'd8, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFDF_F0EF, 6'h0A, 32'hFFFF_FFFC,
                     32'hFFFF_FFFC, 32'hFFFF_FFFC, 5'd1, 1'b1, 1'b0};
        vecs[7]  = '{32'h0080_8067, 6'h0B, R1, 32'd8, 32'd8,
                     5'd0, 1'b0, 1'b0};
        vecs[8]  = '{32'hFE20_8CE3, 6'h10, R1, R2, 32'hFFFF_FFF8,
                     5'd25, 1'b0, 1'b0};
        vecs[9]  = '{32'h00C1_2203, 6'h1A, R1, 32'd12, 32'd12,
                     5'd4, 1'b1, 1'b0};
        vecs[10] = '{32'hFE53_2E23, 6'h1A, R1, R2, 32'hFFFF_FFFC,
                     5'd28, 1'b0, 1'b0};
        vecs[11] = '{32'hFE53_3E23, 6'h1B, R1, R2, 32'hFFFF_FFFC,
                     5'd28, 1'b0, 1'b1};
        vecs[12] = '{32'h0000_00FF, 6'h00, 32'h0, 32'h0, 32'h0,
                     5'd1, 1'b0, 1'b1};

        rst      = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h0000_0100;
        if_inst  = 32'h0050_0093;
        rf_data1 = R1;
        rf_data2 = R2;
        fwd_we   = '0;
        fwd_wd   = '0;
        fwd_pend = '0;
        fwd_data = '0;
        ex_ready = 1'b1;

        step();
        step();
        chk("rst ex_valid", 32'(ex_valid), 32'd0);
        chk("rst id_ready", 32'(id_ready), 32'd0);
        chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst ex_opr2", ex_opr2, 32'd0);

        rst = 1'b1;
        #1;
        chk("first id_ready", 32'(id_ready), 32'd1);
        step();
        chk("first ex_valid", 32'(ex_valid), 32'd1);
        chk("first opr1", ex_opr1, 32'd0);
        chk("first opr2", ex_opr2, 32'd5);
        chk("first wd", 32'(ex_wd), 32'd1);
        chk("first wreg", 32'(ex_wreg), 32'd1);
        chk("first opr4", ex_opr4, 32'h100);

        for (int i = 0; i < 13; i++) begin
            if_inst = vecs[i].inst;
            if_pc   = 32'h1000 + 32'(i * 4);
            #1;
            chk($sformatf("v%0d id_ready", i), 32'(id_ready), 32'd1);
            step();
            chk($sformatf("v%0d valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d alusel", i), 32'(ex_alusel),
                32'(vecs[i].sel));
            chk($sformatf("v%0d opr1", i), ex_opr1, vecs[i].o1);
            chk($sformatf("v%0d opr2", i), ex_opr2, vecs[i].o2);
            chk($sformatf("v%0d opr3", i), ex_opr3, vecs[i].o3);
            chk($sformatf("v%0d opr4", i), ex_opr4,
                32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d wd", i), 32'(ex_wd), 32'(vecs[i].wd));
            chk($sformatf("v%0d wreg", i), 32'(ex_wreg),
                32'(vecs[i].wreg));
            chk($sformatf("v%0d illegal", i), 32'(ex_illegal),
                32'(vecs[i].ill));
            chk($sformatf("v%0d inst", i), ex_inst, vecs[i].inst);
        end

        // add x3,x1,x2: both slots target x1, youngest must win
        if_inst = 32'h0020_81B3;
        set_slot(0, 1'b1, 5'd1, 1'b0, 32'h0000_000B);
        set_slot(1, 1'b1, 5'd1, 1'b0, 32'h0000_000A);
        step();
        chk("fwd young opr1", ex_opr1, 32'h0000_000B);
        chk("fwd young opr2", ex_opr2, R2);

        // slot0 targets another reg, slot1 decides; slot2 disabled
        set_slot(0, 1'b1, 5'd7, 1'b0, 32'h0000_000B);
        set_slot(2, 1'b0, 5'd2, 1'b0, 32'h0000_00CC);
        step();
        chk("fwd slot1 opr1", ex_opr1, 32'h0000_000A);
        chk("fwd we0 opr2", ex_opr2, R2);

        // load-use: addi x6,x5,1 with x5 pending in slot0
        fwd_we   = '0;
        if_inst  = 32'h0012_8313;
        set_slot(0, 1'b1, 5'd5, 1'b1, 32'h0000_0055);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("lu id_ready c%0d", c), 32'(id_ready), 32'd0);
            step();
        end
        chk("lu stall_cnt", 32'(stall_cnt), 32'd3);
        chk("lu bubble", 32'(ex_valid), 32'd0);
        set_slot(0, 1'b1, 5'd5, 1'b0, 32'h0000_0055);
        #1;
        chk("lu release ready", 32'(id_ready), 32'd1);
        step();
        chk("lu valid", 32'(ex_valid), 32'd1);
        chk("lu opr1", ex_opr1, 32'h0000_0055);
        chk("lu opr2", ex_opr2, 32'd1);
        chk("lu stall hold", 32'(stall_cnt), 32'd3);

        // back-pressure: output held while inputs churn
        ex_ready = 1'b0;
        if_inst  = 32'h1234_53B7;
        for (int c = 0; c < 4; c++) begin
            set_slot(0, 1'b1, 5'd5, 1'b0, 32'(c + 16'h0700));
            rf_data1 = 32'(c);
            #1;
            chk($sformatf("bp id_ready c%0d", c), 32'(id_ready), 32'd0);
            step();
            chk($sformatf("bp valid c%0d", c), 32'(ex_valid), 32'd1);
            chk($sformatf("bp inst c%0d", c), ex_inst, 32'h0012_8313);
            chk($sformatf("bp opr1 c%0d", c), ex_opr1, 32'h0000_0055);
        end
        ex_ready = 1'b1;
        #1;
        chk("b2b id_ready", 32'(id_ready), 32'd1);
        step();
        chk("b2b valid", 32'(ex_valid), 32'd1);
        chk("b2b inst", ex_inst, 32'h1234_53B7);

        // flush while FULL with a valid input: nothing accepted
        fwd_we  = '0;
        flush   = 1'b1;
        if_inst = 32'h0020_81B3;
        #1;
        chk("flush id_ready", 32'(id_ready), 32'd0);
        step();
        chk("flush valid", 32'(ex_valid), 32'd0);
        chk("flush inst", ex_inst, 32'h1234_53B7);
        flush    = 1'b0;
        if_valid = 1'b0;
        step();
        chk("flush idle valid", 32'(ex_valid), 32'd0);
        chk("final stall_cnt", 32'(stall_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
